// File: rtl/rx_phase_sync_pkg.sv
// rx_phase_sync_pkg: shared RX datapath defaults, FSM encoding and log2 helper
package rx_phase_sync_pkg;

    function automatic int log2(input int v);
        int r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v)
                r = i + 1;
        return r;
    endfunction

    localparam int DEF_NB        = 8;
    localparam int DEF_OS        = 4;
    localparam int DEF_NB_PH     = log2(DEF_OS);
    localparam int DEF_LOG2_NSYM = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACQ   = 2'd1,
        TRACK = 2'd2
    } state_t;

endpackage

// File: rtl/phase_energy_acc.sv
// phase_energy_acc: |sample| energy accumulated per oversampling phase
module phase_energy_acc
    import rx_phase_sync_pkg::*;
#(
    parameter int NB     = DEF_NB,
    parameter int OS     = DEF_OS,
    parameter int NB_PH  = DEF_NB_PH,
    parameter int NB_ACC = DEF_NB + DEF_LOG2_NSYM
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic signed [NB-1:0]         sample,
    input  logic        [NB_PH-1:0]      phase,
    input  logic                         enable,
    input  logic                         reload,
    output logic [OS-1:0][NB_ACC-1:0]    acc
);

    logic [NB-1:0]     mag;
    logic [NB_ACC-1:0] energy;

    // Unsigned NB-bit magnitude: the most negative code maps to 2^(NB-1) exactly
    assign mag    = sample[NB-1] ? NB'(-sample) : NB'(sample);
    assign energy = NB_ACC'(mag);

    always_ff @(posedge clock or posedge reset)
        if (reset)
            acc <= '0;
        else if (!enable)
            acc <= '0;
        else if (reload)
            acc <= {{((OS - 1) * NB_ACC){1'b0}}, energy};
        else
            acc[phase] <= acc[phase] + energy;

endmodule

// File: rtl/rx_phase_sync.sv
// rx_phase_sync: picks the strongest oversampling phase per window and emits
// one hard-decision bit per symbol at that phase
module rx_phase_sync
    import rx_phase_sync_pkg::*;
#(
    parameter int NB        = DEF_NB,
    parameter int OS        = DEF_OS,
    parameter int NB_PH     = DEF_NB_PH,
    parameter int LOG2_NSYM = DEF_LOG2_NSYM,
    parameter int NB_ACC    = NB + LOG2_NSYM
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_enable,
    input  logic                  i_valid,
    input  logic signed [NB-1:0]  i_sample,
    output logic [NB_PH-1:0]      o_offset,
    output logic                  o_locked,
    output logic signed [NB-1:0]  o_sample,
    output logic                  o_bit,
    output logic                  o_bit_valid
);

    state_t                    state;
    logic [NB_PH-1:0]          ph;
    logic [NB_PH-1:0]          cur_ph;
    logic [NB_PH-1:0]          best;
    logic [NB_PH-1:0]          new_off;
    logic [LOG2_NSYM-1:0]      sym;
    logic [OS-1:0][NB_ACC-1:0] acc;
    logic [NB_ACC-1:0]         max_val;
    logic                      run;
    logic                      win_end;
    logic                      fire;

    // The strobe cycle always carries phase 0, even if it arrives misaligned
    assign cur_ph  = i_valid ? '0 : ph;
    assign run     = i_enable && (state != IDLE || i_valid);
    assign win_end = i_enable && state != IDLE && i_valid && &sym;
    assign fire    = i_enable && state != IDLE && cur_ph == o_offset;
    assign new_off = acc[o_offset] == max_val ? o_offset : best;

    always_comb begin
        best    = '0;
        max_val = acc[0];
        for (int i = 1; i < OS; i++)
            if (acc[i] > max_val) begin
                best    = NB_PH'(i);
                max_val = acc[i];
            end
    end

    phase_energy_acc #(
        .NB     (NB),
        .OS     (OS),
        .NB_PH  (NB_PH),
        .NB_ACC (NB_ACC)
    ) u_acc (
        .clock  (clock),
        .reset  (reset),
        .sample (i_sample),
        .phase  (cur_ph),
        .enable (run),
        .reload (win_end),
        .acc    (acc)
    );

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state       <= IDLE;
            ph          <= '0;
            sym         <= '0;
            o_offset    <= '0;
            o_locked    <= 1'b0;
            o_sample    <= '0;
            o_bit       <= 1'b0;
            o_bit_valid <= 1'b0;
        end else begin
            state       <= !i_enable ? IDLE : win_end ? TRACK : (state == IDLE && i_valid) ? ACQ : state;
            ph          <= run ? (i_valid ? NB_PH'(1) : ph + 1'b1) : '0;
            sym         <= (run && state != IDLE) ? sym + LOG2_NSYM'(i_valid) : '0;
            o_locked    <= i_enable && (o_locked || win_end);
            o_bit_valid <= fire;
            if (win_end)
                o_offset <= new_off;
            if (fire) begin
                o_sample <= i_sample;
                o_bit    <= i_sample[NB-1];
            end
        end

endmodule

// File: tb/tb_rx_phase_sync.sv
// tb_rx_phase_sync: directed window table plus hand sequences for rx_phase_sync
module tb_rx_phase_sync;

    logic              clock  = 1'b0;
    logic              reset  = 1'b1;
    logic              enable = 1'b0;
    logic              valid  = 1'b0;
    logic signed [7:0] sample = '0;
    logic [1:0]        offset;
    logic              locked;
    logic signed [7:0] sample_o;
    logic              bit_o;
    logic              bit_valid;

    int checks = 0;
    int errors = 0;
    int cur_off;
    bit active;

    always #5 clock = ~clock;

    rx_phase_sync #(.NB(8), .OS(4), .NB_PH(2), .LOG2_NSYM(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .i_enable    (enable),
        .i_valid     (valid),
        .i_sample    (sample),
        .o_offset    (offset),
        .o_locked    (locked),
        .o_sample    (sample_o),
        .o_bit       (bit_o),
        .o_bit_valid (bit_valid)
    );

    typedef logic [3:0][7:0] mags_t;
    typedef struct {
        mags_t a1;
        mags_t a2;
        int    sw;
        int    exp_off;
    } row_t;

    row_t rows[8];

    function automatic mags_t mk(input int m0, input int m1, input int m2, input int m3);
        mags_t m;
        m[0] = 8'(m0);
        m[1] = 8'(m1);
        m[2] = 8'(m2);
        m[3] = 8'(m3);
        return m;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic v, input logic signed [7:0] s);
        valid  = v;
        sample = s;
        @(posedge clock);
        #1;
    endtask

    task automatic symbol(input mags_t m, input bit neg);
        logic signed [7:0] s;
        for (int p = 0; p < 4; p++) begin
            s = m[p];
            if (neg)
                s = -s;
            cyc(p == 0, s);
        end
    endtask

    task automatic do_reset;
        reset  = 1'b1;
        enable = 1'b0;
        valid  = 1'b0;
        sample = '0;
        @(posedge clock);
        #1;
        chk("reset_offset", offset, 0);
        chk("reset_locked", locked, 0);
        chk("reset_sample", sample_o, 0);
        chk("reset_bit", bit_o, 0);
        chk("reset_bit_valid", bit_valid, 0);
        reset = 1'b0;
    endtask

    // Each row is one 16-symbol window; its decision shows at the next row's first strobe
    task automatic run_rows;
        int                mag;
        logic signed [7:0] smp;
        bit                bv;
        active  = 0;
        cur_off = 0;
        for (int r = 0; r <= 8; r++)
            for (int s = 0; s < 16; s++)
                for (int p = 0; p < 4; p++) begin
                    if (r == 8 && (s != 0 || p != 0))
                        continue;
                    mag = r == 8 ? 0 : (s < rows[r].sw ? int'(rows[r].a1[p]) : int'(rows[r].a2[p]));
                    smp = 8'(s[0] ? -mag : mag);
                    bv  = active && p == cur_off;
                    cyc(p == 0, smp);
                    if (r > 0 && s == 0 && p == 0)
                        cur_off = rows[r-1].exp_off;
                    if (p == 0) begin
                        chk("row_offset", offset, cur_off);
                        chk("row_locked", locked, r > 0);
                    end
                    chk("row_bit_valid", bit_valid, bv);
                    if (bv) begin
                        chk("row_bit", bit_o, smp < 0);
                        chk("row_sample", sample_o, smp);
                    end
                    active = 1;
                end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rows[0] = '{mk(50, 50, 50, 50),   mk(50, 50, 50, 50),   16, 0};
        rows[1] = '{mk(10, 10, 10, 100),  mk(10, 10, 10, 100),  16, 3};
        rows[2] = '{mk(50, 50, 50, 50),   mk(50, 50, 50, 50),   16, 3};
        rows[3] = '{mk(10, 100, 10, 10),  mk(10, 100, 10, 10),  16, 1};
        rows[4] = '{mk(10, 100, 10, 10),  mk(10, 10, 10, 100),  8,  1};
        rows[5] = '{mk(10, 10, 10, 100),  mk(10, 10, 10, 100),  16, 3};
        rows[6] = '{mk(10, 10, 100, 10),  mk(10, 10, 100, 10),  16, 2};
        rows[7] = '{mk(60, 10, 10, 60),   mk(60, 10, 10, 60),   16, 0};

        do_reset();
        enable = 1'b1;
        run_rows();

        // Full scale: -128 everywhere must reach 2048 per phase without wrap
        do_reset();
        enable = 1'b1;
        for (int s = 0; s < 16; s++)
            symbol(mk(128, 128, 128, 128), 1);
        for (int i = 0; i < 4; i++)
            chk("fs_acc", dut.acc[i], 2048);
        cyc(1, 8'sh80);
        chk("fs_offset", offset, 0);
        chk("fs_locked", locked, 1);
        chk("fs_bit_valid", bit_valid, 1);
        chk("fs_bit", bit_o, 1);
        chk("fs_acc0_reload", dut.acc[0], 128);
        chk("fs_acc1_reload", dut.acc[1], 0);

        // Window-end sample belongs to the next window only
        do_reset();
        enable = 1'b1;
        for (int s = 0; s < 16; s++)
            symbol(mk(5, 10, 5, 5), s[0]);
        cyc(1, 8'sd127);
        chk("bnd_offset", offset, 1);
        chk("bnd_locked", locked, 1);
        chk("bnd_acc0", dut.acc[0], 127);
        for (int i = 1; i < 4; i++)
            chk("bnd_acc_other", dut.acc[i], 0);

        // Enable drop mid-window, fresh acquisition, then async reset
        do_reset();
        enable = 1'b1;
        for (int s = 0; s < 17; s++)
            symbol(mk(10, 10, 100, 10), 0);
        chk("en_offset_lock", offset, 2);
        chk("en_locked_lock", locked, 1);
        for (int s = 2; s < 7; s++)
            symbol(mk(10, 10, 100, 10), 0);
        enable = 1'b0;
        cyc(1, 8'sd10);
        chk("en_drop_locked", locked, 0);
        chk("en_drop_bit_valid", bit_valid, 0);
        chk("en_drop_offset", offset, 2);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 8'sd100);
            chk("en_idle_bit_valid", bit_valid, 0);
        end
        enable = 1'b1;
        for (int s = 0; s < 16; s++)
            symbol(mk(10, 100, 10, 10), 0);
        chk("re_locked_early", locked, 0);
        chk("re_offset_early", offset, 2);
        cyc(1, 8'sd10);
        chk("re_offset", offset, 1);
        chk("re_locked", locked, 1);
        for (int s = 0; s < 5; s++)
            symbol(mk(10, 100, 10, 10), 0);
        #2 reset = 1'b1;
        #1;
        chk("arst_offset", offset, 0);
        chk("arst_locked", locked, 0);
        chk("arst_sample", sample_o, 0);
        chk("arst_bit", bit_o, 0);
        chk("arst_bit_valid", bit_valid, 0);
        for (int i = 0; i < 4; i++)
            chk("arst_acc", dut.acc[i], 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int s = 0; s < 16; s++)
            symbol(mk(10, 10, 10, 100), 0);
        chk("arst_relock_early", locked, 0);
        cyc(1, 8'sd10);
        chk("arst_relock_offset", offset, 3);
        chk("arst_relock", locked, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
